// File: rtl/freq_interp.sv
`default_nettype none
// ============================================================================
// Module   : freq_interp
// Brief    : NB-IoT frequency-domain interpolator; four NRS pilot estimates
//            per component in, 12 per-subcarrier estimates streamed out.
// Revision : 1.0  initial release
// ============================================================================
module freq_interp #(
  parameter int WIDTH_EST = 17,
  parameter int OUT_WIDTH = 17
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [2:0]                  v_shift,
  input  logic signed [WIDTH_EST-1:0] e1_re,
  input  logic signed [WIDTH_EST-1:0] e2_re,
  input  logic signed [WIDTH_EST-1:0] e3_re,
  input  logic signed [WIDTH_EST-1:0] e4_re,
  input  logic signed [WIDTH_EST-1:0] e1_im,
  input  logic signed [WIDTH_EST-1:0] e2_im,
  input  logic signed [WIDTH_EST-1:0] e3_im,
  input  logic signed [WIDTH_EST-1:0] e4_im,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] h_re,
  output logic signed [OUT_WIDTH-1:0] h_im,
  output logic [3:0]                  sc_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int c_TW = WIDTH_EST + 2;
  localparam int c_PW = WIDTH_EST + 11;
  localparam logic signed [c_PW-1:0] c_THIRD = c_PW'(171);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [WIDTH_EST-1:0] r_pre [0:3];
  logic signed [WIDTH_EST-1:0] r_pim [0:3];
  logic [1:0]                  r_off;
  logic                        r_valid;
  logic [3:0]                  r_idx;
  logic signed [OUT_WIDTH-1:0] r_h_re;
  logic signed [OUT_WIDTH-1:0] r_h_im;

  logic                        w_xfer;
  logic                        w_last;
  logic                        w_load;
  logic                        w_busy;
  logic                        w_done;
  logic [3:0]                  w_k;
  logic signed [OUT_WIDTH-1:0] w_h_re;
  logic signed [OUT_WIDTH-1:0] w_h_im;

  function automatic logic [1:0] f_mod3(input logic [2:0] v);
    case (v)
      3'd0, 3'd3, 3'd6: f_mod3 = 2'd0;
      3'd1, 3'd4, 3'd7: f_mod3 = 2'd1;
      default:          f_mod3 = 2'd2;
    endcase
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] f_sat(input logic signed [c_TW-1:0] v);
    longint lv;
    longint lmax;
    longint lmin;
    lv   = longint'(v);
    lmax = (64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1;
    lmin = -(64'sd1 <<< (OUT_WIDTH - 1));
    if (lv > lmax)
      lv = lmax;
    else if (lv < lmin)
      lv = lmin;
    return lv[OUT_WIDTH-1:0];
  endfunction

  // One component of one subcarrier: hold outside the pilot span, exact at
  // pilots, and 2:1 / 1:2 weighted thirds between neighbouring pilots.
  function automatic logic signed [OUT_WIDTH-1:0] f_interp(
    input logic [3:0]                  k,
    input logic [1:0]                  o,
    input logic signed [WIDTH_EST-1:0] p0,
    input logic signed [WIDTH_EST-1:0] p1,
    input logic signed [WIDTH_EST-1:0] p2,
    input logic signed [WIDTH_EST-1:0] p3
  );
    logic [3:0]                  d;
    logic [1:0]                  j;
    logic [1:0]                  r;
    logic signed [WIDTH_EST-1:0] ea;
    logic signed [WIDTH_EST-1:0] eb;
    logic signed [c_TW-1:0]      ta;
    logic signed [c_TW-1:0]      tb;
    logic signed [c_TW-1:0]      t;
    logic signed [c_PW-1:0]      prod;
    logic signed [c_TW-1:0]      res;

    d = k - {2'b00, o};
    case (d)
      4'd0, 4'd1, 4'd2: j = 2'd0;
      4'd3, 4'd4, 4'd5: j = 2'd1;
      4'd6, 4'd7, 4'd8: j = 2'd2;
      default:          j = 2'd3;
    endcase
    case (d)
      4'd1, 4'd4, 4'd7: r = 2'd1;
      4'd2, 4'd5, 4'd8: r = 2'd2;
      default:          r = 2'd0;
    endcase
    case (j)
      2'd0:    begin ea = p0; eb = p1; end
      2'd1:    begin ea = p1; eb = p2; end
      2'd2:    begin ea = p2; eb = p3; end
      default: begin ea = p3; eb = p3; end
    endcase

    ta = {{2{ea[WIDTH_EST-1]}}, ea};
    tb = {{2{eb[WIDTH_EST-1]}}, eb};
    if (r == 2'd1)
      t = (ta <<< 1) + tb;
    else
      t = ta + (tb <<< 1);
    // x*171/512 approximates x/3; taking bits above 9 is a floor shift
    prod = $signed({{(c_PW-c_TW){t[c_TW-1]}}, t}) * c_THIRD;

    if (k < {2'b00, o})
      res = {{2{p0[WIDTH_EST-1]}}, p0};
    else if (d > 4'd9)
      res = {{2{p3[WIDTH_EST-1]}}, p3};
    else if (r == 2'd0)
      res = ta;
    else
      res = prod[c_TW+8:9];
    return f_sat(res);
  endfunction

  assign w_xfer = r_valid & out_ready;
  assign w_last = w_xfer & (r_idx == 4'd11);
  assign w_load = (r_state == S_RUN) & (~r_valid | (w_xfer & (r_idx != 4'd11)));
  assign w_k    = r_valid ? (r_idx + 4'd1) : 4'd0;

  assign w_h_re = f_interp(w_k, r_off, r_pre[0], r_pre[1], r_pre[2], r_pre[3]);
  assign w_h_im = f_interp(w_k, r_off, r_pim[0], r_pim[1], r_pim[2], r_pim[3]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last)
          w_state_nxt = S_FIN;
      end
      S_FIN: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        r_pre[i] <= '0;
        r_pim[i] <= '0;
      end
      r_off   <= 2'd0;
      r_valid <= 1'b0;
      r_idx   <= 4'd0;
      r_h_re  <= '0;
      r_h_im  <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_pre[0] <= e1_re;
        r_pre[1] <= e2_re;
        r_pre[2] <= e3_re;
        r_pre[3] <= e4_re;
        r_pim[0] <= e1_im;
        r_pim[1] <= e2_im;
        r_pim[2] <= e3_im;
        r_pim[3] <= e4_im;
        r_off    <= f_mod3(v_shift);
      end
      // Next beat is registered on the same edge the current one transfers
      if (w_load) begin
        r_valid <= 1'b1;
        r_idx   <= w_k;
        r_h_re  <= w_h_re;
        r_h_im  <= w_h_im;
      end else if (w_last) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign h_re      = r_h_re;
  assign h_im      = r_h_im;
  assign sc_idx    = r_idx;
  assign busy      = w_busy;
  assign done      = w_done;

endmodule
`default_nettype wire

// File: doc/freq_interp.md
Name: freq_interp

Overview:
- Frequency-domain linear interpolator for the NB-IoT channel estimator, directly downstream of the pilot averaging stage.
- Takes the four averaged NRS pilot estimates per component (real and imaginary) plus v_shift.
- Streams 12 per-subcarrier channel estimates for one PRB, one subcarrier per accepted beat, under a valid/ready handshake.
- Feeds the equalizer.

Parameters:
- WIDTH_EST, 17, width of input pilot estimates E1..E4 (signed, per component).
- OUT_WIDTH, 17, width of output estimates h_re/h_im (signed, saturated).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to interpolate the currently presented E1..E4; sampled only in IDLE
- v_shift  in  3  cell NRS shift; offset o = v_shift mod 3
- e1_re, e2_re, e3_re, e4_re  in  WIDTH_EST each  averaged pilot estimates, real part
- e1_im, e2_im, e3_im, e4_im  in  WIDTH_EST each  averaged pilot estimates, imaginary part
- out_ready  in  1  downstream accepts the current beat
- out_valid  out  1  h_re/h_im/sc_idx valid
- h_re  out  OUT_WIDTH  interpolated estimate, real part
- h_im  out  OUT_WIDTH  interpolated estimate, imaginary part
- sc_idx  out  4  subcarrier index 0..11 of the current beat
- busy  out  1  high from the edge that accepts start until the final beat is transferred
- done  out  1  one-cycle pulse on the cycle after the 12th beat is transferred

Behaviour:
- Reset (rst low, async): state IDLE; out_valid=0, h_re=h_im=0, sc_idx=0, busy=0, done=0; latched pilots and offset cleared. Reset mid-run aborts the run with no further beats.
- FSM states: IDLE, RUN, FIN.
  - IDLE -> RUN on start=1. That edge latches all eight E inputs and o = v_shift mod 3; v_shift 6 and 7 map to o = 0 and 1.
  - The first beat (sc_idx=0) is registered valid on the next edge, so out_valid rises 1 cycle after the start edge. busy=1 from that same edge.
  - RUN: a beat transfers when out_valid and out_ready are both high. On transfer sc_idx increments and the next beat is registered on the same edge, giving one beat per cycle while ready is held high.
  - While out_ready=0, h_re, h_im, sc_idx and out_valid hold stable.
  - Transfer of sc_idx=11 -> FIN. out_valid=0 and busy=0 on that edge.
  - FIN: done=1 for exactly one cycle, then -> IDLE.
  - start is ignored outside IDLE, including during FIN. It needs no queueing.
- Pilot positions: E1..E4 sit at subcarriers o, o+3, o+6, o+9, in ascending order. The upstream stage already delivers them ordered.
- Per component, for subcarrier k:
  - k < o: hold E1.
  - k = o+3j: Ej+1, passed through exactly.
  - k = o+3j+1: third(2*Ej+1 + Ej+2).
  - k = o+3j+2: third(Ej+1 + 2*Ej+2).
  - k > o+9: hold E4.
- third(t): t is a signed sum, WIDTH_EST+2 bits wide. The result is (t * 171) arithmetic-shifted right by 9, i.e. floor rounding, then saturated to OUT_WIDTH.
- Real and imaginary parts use identical, independent datapaths.
- Latched pilots are stable for the whole run. Changes on the E inputs after the start edge have no effect.
- Throughput with out_ready tied high: 12 beats in 12 consecutive cycles, then done. The next start is accepted no earlier than the cycle after done.

Test Plan:
- v_shift=1 (o=1), e_re = 300, 0, -300, 600, out_ready=1. Required h_re for k=0..11: 300, 300, 200, 100, 0, -101, -201, -300, 0, 300, 600, 600. out_valid high for 12 consecutive cycles starting 1 cycle after start; done one cycle after the k=11 beat.
- v_shift=0 (o=0), e_im = -300, 0, 0, 0. Required h_im: k0=-300, k1=-201, k2=-101, k3..k11=0. Real path with all-zero pilots outputs all zeros.
- v_shift=5 (o=2): pilots appear exactly at k=2, 5, 8, 11; k=0 and k=1 equal E1; no beat beyond k=11. v_shift=7 behaves as o=1.
- Backpressure: out_ready low for 3 cycles during the k=4 beat. h_re, h_im and sc_idx=4 must hold stable and no beat may be skipped or repeated. Total run is 15 cycles.
- Saturation: e_re = 65535 (max positive 17-bit) for all four pilots, then -65536 for all four. Outputs must equal the inputs with no wrap.
- Control: start pulsed mid-run is ignored. Async rst low at k=6 forces all outputs to 0 immediately. A new start after release produces a complete 12-beat run from k=0.
